uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised successor to the fixed 8N1 debounced-button UART transmitter. It supports configurable data width, parity, stop bits and baud divisor. A FIFO buffers characters, fed either by a streaming write port or by the debounced rising edge of a push button. The block sits between board I/O (button, switch data) or an on-chip producer and the serial TxD pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (>=2); 434 gives 115200 baud at 50 MHz
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
DEBOUNCE_CYCLES, 500000, cycles the synchronised button must be stable before it is accepted (>=2)
FIFO_DEPTH, 16, FIFO entries, power of 2, >=2

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset
TxD_Enable  in  1  raw, bouncy push button, asynchronous to clk
Data  in  DATA_BITS  character pushed on an accepted button edge
wr_valid  in  1  streaming push strobe
wr_data  in  DATA_BITS  streaming push data
wr_ready  out  1  high when FIFO not full
TxD  out  1  serial line, registered, idle high
busy  out  1  high while a frame is on the line (START..STOP)
overflow  out  1  sticky: a push was dropped
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): TxD=1, busy=0, overflow=0, fifo_count=0, wr_ready=1, FSM=IDLE, debounced level=0, debounce counter=0, FIFO pointers=0.
- Button path: 2-flop synchroniser on TxD_Enable. When the synchronised value differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the debounced level is updated. Any return to the old value clears the counter. A 0->1 transition of the debounced level generates a single one-cycle push of Data. Holding the button generates no repeat pushes.
- Push arbitration: wr_valid has priority. A button push in the same cycle as wr_valid=1 is dropped and sets overflow.
- FIFO: a push while full is dropped, sets overflow, and leaves the contents unchanged. A push and a pop in the same cycle keep fifo_count unchanged, including when the FIFO is full. Pointers wrap modulo FIFO_DEPTH. overflow clears only on reset.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Baud counter runs 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles.
- IDLE: TxD=1. If fifo_count>0, pop the head into the shift register, go to START, and drive TxD=0 on the same edge.
- Latency: a push into an empty FIFO with the FSM in IDLE, sampled at edge n, gives TxD=0 after edge n+1.
- DATA: send DATA_BITS bits, LSB first.
- PARITY: present only if PARITY!=0. Odd parity makes the total number of ones in data plus parity odd. Even parity makes it even.
- STOP: TxD=1 for STOP_BITS*CLKS_PER_BIT cycles. At the last stop cycle:
  - FIFO non-empty: pop and enter START directly, with no idle cycle (back-to-back frames).
  - FIFO empty: go to IDLE.
- busy=1 in every state except IDLE.
- Frame length in cycles: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT.
- Reset mid-frame: TxD returns to 1 immediately (asynchronously) and the FIFO is emptied. The partial frame is not resumed.

Test Plan:
- Reset, then idle 100 cycles -> TxD=1, busy=0, wr_ready=1, fifo_count=0, overflow=0.
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; wr_data=0x55 with one wr_valid pulse -> TxD low 2 edges later. Bit sequence 0,1,0,1,0,1,0,1,0, parity 0, stop 1, each bit 4 cycles, 44 cycles total, then busy=0.
- Same configuration, PARITY=1, 0x07 -> parity bit 0. STOP_BITS=2 -> high for 8 cycles before IDLE.
- DEBOUNCE_CYCLES=8; button bounces 1/0 every 3 cycles for 30 cycles, then held high for 20 cycles with Data=0x41 -> exactly one push. One frame of 0x41; fifo_count peaks at 1.
- FIFO_DEPTH=4; 6 consecutive wr_valid pushes 0x10..0x15 while idle -> the first is popped at once. 0x10..0x14 are sent back-to-back with no idle gap, 0x15 is dropped, and overflow=1 stays set.
- Assert reset low mid-DATA of frame 2 of 3 queued -> TxD=1, busy=0, fifo_count=0 at once. After release, the line stays idle.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: debounced push button or streaming write
// port feeds a small FIFO; a frame FSM serialises characters onto TxD with
// configurable data width, parity, stop bits and baud divisor.
module uart_tx_param #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            TxD_Enable,
  input  logic [DATA_BITS-1:0]            Data,
  input  logic                            wr_valid,
  input  logic [DATA_BITS-1:0]            wr_data,
  output logic                            wr_ready,
  output logic                            TxD,
  output logic                            busy,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int BIT_W  = $clog2(DATA_BITS);

  typedef struct packed {
    logic                 vld;
    logic [DATA_BITS-1:0] data;
  } push_req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Button path: synchroniser, debouncer, rising-edge push pulse
  // ---------------------------------------------------------------------
  logic [1:0]       sync_pipe;
  logic             deb_level;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_push;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], TxD_Enable};
  end

  // Accept a new level only after it has been stable for DEBOUNCE_CYCLES;
  // emit a single-cycle push on the accepted 0->1 transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      btn_push  <= 1'b0;
    end else begin
      btn_push <= 1'b0;
      if (sync_pipe[1] != deb_level) begin
        if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_level <= sync_pipe[1];
          deb_cnt   <= '0;
          btn_push  <= sync_pipe[1];
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Push arbitration: the streaming port wins; a colliding button push is lost
  // ---------------------------------------------------------------------
  push_req_t push;
  logic      btn_drop;

  always_comb begin
    push.vld  = wr_valid | btn_push;
    push.data = wr_valid ? wr_data : Data;
    btn_drop  = wr_valid & btn_push;
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 full, have_data, pop, push_ok;
  logic [DATA_BITS-1:0] head;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic                 baud_last, stop_last;

  always_comb begin
    full      = (fifo_count == CNT_W'(FIFO_DEPTH));
    have_data = (fifo_count != '0);
    head      = mem[rd_ptr];
    // A full FIFO still takes a push when a pop frees the slot in the same cycle.
    push_ok   = push.vld & (~full | pop);
  end

  assign wr_ready = ~full;

  // Storage array; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push.data;
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (btn_drop | (push.vld & ~push_ok)) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 txd_r, busy_r;

  always_comb begin
    baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    stop_last = (STOP_BITS == 1) || stop_idx;
    // Pop from IDLE, or at the very last stop cycle to chain frames with no gap.
    pop       = have_data & ((state == S_IDLE) |
                             ((state == S_STOP) & baud_last & stop_last));
  end

  // Single registered FSM: each bit is held CLKS_PER_BIT cycles, TxD and busy
  // change on the same edge as the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          txd_r <= 1'b1;
          if (pop) begin
            shreg    <= head;
            par_bit  <= (PARITY == 1) ? ~^head : ^head;
            baud_cnt <= '0;
            txd_r    <= 1'b0;
            busy_r   <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd_r    <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                txd_r <= par_bit;
                state <= S_PARITY;
              end else begin
                txd_r    <= 1'b1;
                stop_idx <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              txd_r   <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            txd_r    <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (stop_last) begin
              if (pop) begin
                shreg   <= head;
                par_bit <= (PARITY == 1) ? ~^head : ^head;
                txd_r   <= 1'b0;
                state   <= S_START;
              end else begin
                txd_r  <= 1'b1;
                busy_r <= 1'b0;
                state  <= S_IDLE;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          txd_r  <= 1'b1;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign TxD  = txd_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two instances (even parity / 1 stop, odd parity /
// 2 stop) share stimulus; a per-instance monitor checks every line cycle
// against frames built from a queue of expected characters.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       TxD_Enable;
  logic [7:0] Data;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       txd [2];
  logic       busy [2];
  logic       wr_ready [2];
  logic       overflow [2];
  logic [2:0] fifo_count [2];

  int         vectors = 0;
  int         errors  = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  // Expected line bits of one frame: start, LSB-first data, parity, stop (1s).
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par);
    logic [15:0] b;
    int ones;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    ones = $countones(d);
    if (par == 1) b[9] = ((ones % 2) == 0);
    if (par == 2) b[9] = ((ones % 2) == 1);
    return b;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int PAR   = (g == 0) ? 2 : 1;
    localparam int STB   = (g == 0) ? 1 : 2;
    localparam int NBITS = 1 + 8 + 1 + STB;

    uart_tx_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR), .STOP_BITS(STB),
      .DEBOUNCE_CYCLES(8), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk), .reset(rst_n), .TxD_Enable(TxD_Enable), .Data(Data),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready[g]),
      .TxD(txd[g]), .busy(busy[g]), .overflow(overflow[g]),
      .fifo_count(fifo_count[g])
    );

    // Monitor: pops the next expected character when a start bit appears.
    initial begin : mon
      logic [15:0] bits;
      int rd_idx, cyc;
      bit infr, must_start;
      rd_idx = 0; cyc = 0; infr = 0; must_start = 0; bits = '1;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          infr = 0; must_start = 0; rd_idx = exp_q.size();
        end else if (!infr) begin
          if (txd[g] === 1'b0) begin
            if (rd_idx < exp_q.size()) begin
              bits = frame_bits(exp_q[rd_idx], PAR);
              infr = 1; cyc = 1; must_start = 0;
              if (busy[g] !== 1'b1) begin
                errors++;
                $display("FAIL dut%0d start_busy: busy=%b required 1 at %0t", g, busy[g], $time);
              end
            end else begin
              errors++;
              $display("FAIL dut%0d unexpected_start: TxD low with nothing queued at %0t", g, $time);
            end
          end else begin
            if (must_start) begin
              errors++;
              $display("FAIL dut%0d frame_gap: TxD=%b required 0 (back-to-back) at %0t", g, txd[g], $time);
              must_start = 0;
            end
            if (busy[g] !== 1'b0) begin
              errors++;
              $display("FAIL dut%0d idle_busy: busy=%b required 0 at %0t", g, busy[g], $time);
            end
          end
        end else begin
          if (txd[g] !== bits[cyc/CPB]) begin
            errors++;
            $display("FAIL dut%0d line_bit%0d: TxD=%b required %b at %0t",
                     g, cyc/CPB, txd[g], bits[cyc/CPB], $time);
          end
          if (busy[g] !== 1'b1) begin
            errors++;
            $display("FAIL dut%0d frame_busy: busy=%b required 1 at %0t", g, busy[g], $time);
          end
          cyc++;
          if (cyc == NBITS * CPB) begin
            infr = 0;
            vectors++;
            rd_idx++;
            must_start = (rd_idx < exp_q.size());
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_both_idle(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_txd%0d", nm, g), int'(txd[g]), 1);
      chk($sformatf("%s_busy%0d", nm, g), int'(busy[g]), 0);
      chk($sformatf("%s_count%0d", nm, g), int'(fifo_count[g]), 0);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy[0] === 1'b0 && busy[1] === 1'b0 &&
                 fifo_count[0] === 3'd0 && fifo_count[1] === 3'd0) && n < 3000);
    chk({nm, "_idle_within_bound"}, int'(n < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  // Push a burst of characters from idle; with depth 4 the first is popped at
  // once, so at most 5 are accepted and the rest are dropped.
  task automatic burst(input int k, input logic [7:0] base, input bit rnd);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = rnd ? 8'($urandom_range(0, 255)) : base + 8'(i);
      if (i < 5) exp_q.push_back(wr_data);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pk [2];
    rst_n = 1'b0; TxD_Enable = 1'b0; Data = '0; wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state after 100 idle cycles
    repeat (100) @(negedge clk);
    chk_both_idle("reset");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset_ready%0d", g), int'(wr_ready[g]), 1);
      chk($sformatf("reset_ovf%0d", g), int'(overflow[g]), 0);
    end

    // 0x55: push-to-start latency, then the monitor checks the whole frame
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk);
    wr_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("lat_edge1_txd%0d", g), int'(txd[g]), 1);
      chk($sformatf("lat_edge1_count%0d", g), int'(fifo_count[g]), 1);
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("lat_edge2_txd%0d", g), int'(txd[g]), 0);
      chk($sformatf("lat_edge2_count%0d", g), int'(fifo_count[g]), 0);
    end
    wait_idle("f55");

    // 0x07: parity 1 even / 0 odd, two stop bits on the second instance
    burst(1, 8'h07, 0);
    wait_idle("f07");

    // Bouncy button then a clean hold: exactly one push of Data
    Data = 8'h41;
    exp_q.push_back(8'h41);
    pk[0] = 0; pk[1] = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      TxD_Enable = ((i / 3) % 2) == 0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      TxD_Enable = 1'b1;
      for (int g = 0; g < 2; g++) if (int'(fifo_count[g]) > pk[g]) pk[g] = int'(fifo_count[g]);
    end
    TxD_Enable = 1'b0;
    for (int g = 0; g < 2; g++) chk($sformatf("btn_peak%0d", g), pk[g], 1);
    wait_idle("btn");
    repeat (20) @(negedge clk);
    for (int g = 0; g < 2; g++) chk($sformatf("btn_ovf%0d", g), int'(overflow[g]), 0);

    // Six pushes into a depth-4 FIFO: 0x10..0x14 sent, 0x15 dropped
    burst(6, 8'h10, 0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("ovf_count%0d", g), int'(fifo_count[g]), 4);
      chk($sformatf("ovf_ready%0d", g), int'(wr_ready[g]), 0);
      chk($sformatf("ovf_flag%0d", g), int'(overflow[g]), 1);
    end
    wait_idle("ovf");

    // Randomised bursts of 1..6 random characters
    for (int t = 0; t < 8; t++) begin
      burst(int'($urandom_range(1, 6)), 8'h00, 1);
      wait_idle("rnd");
    end
    for (int g = 0; g < 2; g++) chk($sformatf("ovf_sticky%0d", g), int'(overflow[g]), 1);

    // Reset in the middle of the second of three queued frames
    burst(3, 8'h00, 1);
    repeat (55) @(negedge clk);
    for (int g = 0; g < 2; g++) chk($sformatf("pre_rst_busy%0d", g), int'(busy[g]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_both_idle("midrst");
    for (int g = 0; g < 2; g++) chk($sformatf("midrst_ovf%0d", g), int'(overflow[g]), 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk_both_idle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
